// File: rtl/ysyx_23060208_pkg.sv
// Shared ysyx_23060208 core constants: default register-file geometry and
// the hard-wired zero register index.
package ysyx_23060208_pkg;

  localparam int REG_WIDTH_DEF  = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int X0_IDX         = 0;

endpackage

// File: rtl/ysyx_23060208_scoreboard.sv
// Register busy scoreboard: one pending bit per architectural register plus
// a registered count of pending destinations.
module ysyx_23060208_scoreboard
  import ysyx_23060208_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        set_en,
  input  logic [REG_WIDTH-1:0]        set_idx,
  input  logic                        clr_en,
  input  logic [REG_WIDTH-1:0]        clr_idx,
  output logic [(2**REG_WIDTH)-1:0]   busy,
  output logic [REG_WIDTH:0]          busy_cnt
);

  localparam int NREG = 2**REG_WIDTH;

  logic [NREG-1:0]    busy_nxt;
  logic [REG_WIDTH:0] cnt_nxt;

  // Clear first so that a same-cycle set of the same index wins; x0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[X0_IDX] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{REG_WIDTH{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ysyx_23060208_opfetch.sv
// Operand fetch / issue stage: reads sources with writeback bypass, stalls on
// RAW/WAW hazards via the scoreboard, and holds one issued instruction.
module ysyx_23060208_opfetch
  import ysyx_23060208_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_WIDTH-1:0]  in_rs1,
  input  logic [REG_WIDTH-1:0]  in_rs2,
  input  logic [REG_WIDTH-1:0]  in_rd,
  input  logic                  in_rd_wen,
  output logic [REG_WIDTH-1:0]  raddr1,
  output logic [REG_WIDTH-1:0]  raddr2,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  wb_valid,
  input  logic [REG_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_wen,
  output logic [REG_WIDTH-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2,
  output logic [REG_WIDTH-1:0]  out_rd,
  output logic                  out_rd_wen,
  output logic [REG_WIDTH:0]    busy_cnt,
  output logic                  err_wb
);

  localparam logic [REG_WIDTH-1:0] X0 = REG_WIDTH'(X0_IDX);

  logic [(2**REG_WIDTH)-1:0] busy;
  logic                      clr;
  logic                      raw1, raw2, waw;
  logic                      out_free;
  logic                      accept;
  logic                      set_en;
  logic [DATA_WIDTH-1:0]     opa_p0, opb_p0;

  // Stage p0: hazard detection, handshake and operand bypass.
  assign clr      = wb_valid && (wb_addr != X0) && !reset;
  assign raw1     = busy[in_rs1] && !(clr && (wb_addr == in_rs1));
  assign raw2     = busy[in_rs2] && !(clr && (wb_addr == in_rs2));
  assign waw      = in_rd_wen && busy[in_rd] && !(clr && (wb_addr == in_rd));
  assign out_free = !out_valid || out_ready;
  assign in_ready = !reset && out_free && !raw1 && !raw2 && !waw;
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && in_rd_wen && (in_rd != X0);

  assign raddr1   = in_rs1;
  assign raddr2   = in_rs2;
  assign rf_wen   = clr;
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

  always_comb begin
    opa_p0 = rdata1;
    opb_p0 = rdata2;
    if (clr && (wb_addr == in_rs1)) opa_p0 = wb_data;
    else if (in_rs1 == X0)          opa_p0 = '0;
    if (clr && (wb_addr == in_rs2)) opb_p0 = wb_data;
    else if (in_rs2 == X0)          opb_p0 = '0;
  end

  // Stage p1: issue register, held while downstream stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_src1   <= '0;
      out_src2   <= '0;
      out_rd     <= '0;
      out_rd_wen <= 1'b0;
      err_wb     <= 1'b0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_src1   <= opa_p0;
        out_src2   <= opb_p0;
        out_rd     <= in_rd;
        out_rd_wen <= in_rd_wen;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      if (clr && !busy[wb_addr]) err_wb <= 1'b1;
    end
  end

  ysyx_23060208_scoreboard #(
    .REG_WIDTH (REG_WIDTH)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (set_en),
    .set_idx  (in_rd),
    .clr_en   (clr),
    .clr_idx  (wb_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_ysyx_23060208_opfetch.sv
// Bench for ysyx_23060208_opfetch: directed scenarios with literal expectations
// followed by random traffic, all compared against a behavioural model.
module tb_ysyx_23060208_opfetch;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_src1, out_src2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [5:0]  busy_cnt;
  logic        err_wb;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment register file (external to the DUT) and the reference model.
  logic [31:0] rf_mem [32];
  bit          m_busy [32];
  bit          m_ov, m_rdwen, m_err;
  logic [31:0] m_src1, m_src2;
  logic [4:0]  m_rd;

  ysyx_23060208_opfetch dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1),
    .out_src2(out_src2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .busy_cnt(busy_cnt), .err_wb(err_wb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb rdata1 = rf_mem[raddr1];
  always_comb rdata2 = rf_mem[raddr2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // One clock cycle: compare every output with the model, then advance both.
  task automatic cyc();
    bit          clr, haz, e_ready, acc;
    logic [31:0] op1, op2;
    #1;
    clr = wb_valid && (wb_addr != 0);
    haz = (m_busy[in_rs1] && !(clr && wb_addr == in_rs1)) ||
          (m_busy[in_rs2] && !(clr && wb_addr == in_rs2)) ||
          (in_rd_wen && m_busy[in_rd] && !(clr && wb_addr == in_rd));
    e_ready = !reset && (!m_ov || out_ready) && !haz;
    op1 = (clr && wb_addr == in_rs1) ? wb_data : (in_rs1 == 0) ? 32'd0 : rf_mem[in_rs1];
    op2 = (clr && wb_addr == in_rs2) ? wb_data : (in_rs2 == 0) ? 32'd0 : rf_mem[in_rs2];

    chk("in_ready",   64'(in_ready),   64'(e_ready));
    chk("raddr1",     64'(raddr1),     64'(in_rs1));
    chk("raddr2",     64'(raddr2),     64'(in_rs2));
    chk("rf_wen",     64'(rf_wen),     64'(clr && !reset));
    chk("rf_waddr",   64'(rf_waddr),   64'(wb_addr));
    chk("rf_wdata",   64'(rf_wdata),   64'(wb_data));
    chk("out_valid",  64'(out_valid),  64'(m_ov));
    chk("out_src1",   64'(out_src1),   64'(m_src1));
    chk("out_src2",   64'(out_src2),   64'(m_src2));
    chk("out_rd",     64'(out_rd),     64'(m_rd));
    chk("out_rd_wen", 64'(out_rd_wen), 64'(m_rdwen));
    chk("busy_cnt",   64'(busy_cnt),   64'(model_cnt()));
    chk("err_wb",     64'(err_wb),     64'(m_err));

    acc = in_valid && e_ready;
    @(posedge clock);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_ov = 0; m_rdwen = 0; m_err = 0; m_src1 = '0; m_src2 = '0; m_rd = '0;
    end else begin
      if (clr) begin
        if (!m_busy[wb_addr]) m_err = 1'b1;
        m_busy[wb_addr] = 1'b0;
        rf_mem[wb_addr] = wb_data;
      end
      if (acc) begin
        m_ov = 1'b1; m_src1 = op1; m_src2 = op2; m_rd = in_rd; m_rdwen = in_rd_wen;
        if (in_rd_wen && in_rd != 0) m_busy[in_rd] = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic idle();
    reset = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
      m_busy[i] = 0;
    end
    m_ov = 0; m_rdwen = 0; m_err = 0; m_src1 = '0; m_src2 = '0; m_rd = '0;
    idle();
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd7;

    // Reset state
    reset = 1;
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    #1 chk("rst_in_ready", 64'(in_ready), 64'd0);
    cyc(); cyc();
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err_wb", 64'(err_wb), 64'd0);
    idle();
    cyc();

    // Basic issue with operand read
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    cyc();
    chk("issue_src1", 64'(out_src1), 64'd5);
    chk("issue_src2", 64'(out_src2), 64'd7);
    chk("issue_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("issue_out_valid", 64'(out_valid), 64'd1);

    // RAW stall on x3 released by writeback with bypass
    issue(5'd3, 5'd0, 5'd4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1 chk("raw_stall", 64'(in_ready), 64'd0);
      cyc();
    end
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hAB;
    #1 chk("raw_release", 64'(in_ready), 64'd1);
    cyc();
    chk("raw_bypass", 64'(out_src1), 64'hAB);
    chk("raw_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("raw_no_err", 64'(err_wb), 64'd0);
    idle();

    // Downstream backpressure then back-to-back accepts
    issue(5'd1, 5'd0, 5'd0, 1'b0);
    cyc();
    issue(5'd2, 5'd0, 5'd0, 1'b0);
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
      cyc();
      chk("bp_hold_src1", 64'(out_src1), 64'd5);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1;
    #1 chk("bp_release", 64'(in_ready), 64'd1);
    cyc();
    chk("b2b_first", 64'(out_src1), 64'd7);
    issue(5'd1, 5'd0, 5'd0, 1'b0);
    cyc();
    chk("b2b_second", 64'(out_src1), 64'd5);
    chk("b2b_valid", 64'(out_valid), 64'd1);

    // x0 destination and source; writeback to x0 is ignored
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1 chk("x0_rf_wen", 64'(rf_wen), 64'd0);
    cyc();
    chk("x0_busy_cnt", 64'(busy_cnt), 64'd0);
    issue(5'd0, 5'd0, 5'd1, 1'b0);
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h1234;
    #1 chk("x0_wb_rf_wen", 64'(rf_wen), 64'd0);
    cyc();
    chk("x0_src1", 64'(out_src1), 64'd0);
    chk("x0_no_err", 64'(err_wb), 64'd0);
    idle();

    // Unexpected writeback is sticky
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h99;
    cyc();
    idle();
    chk("err_set", 64'(err_wb), 64'd1);
    for (int k = 0; k < 3; k++) cyc();
    chk("err_sticky", 64'(err_wb), 64'd1);

    // Reset discards in-flight state
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    cyc();
    issue(5'd0, 5'd0, 5'd6, 1'b1);
    cyc();
    chk("pre_rst_cnt", 64'(busy_cnt), 64'd2);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1;
    issue(5'd1, 5'd2, 5'd7, 1'b1);
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h55;
    #1 chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    cyc();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_cnt", 64'(busy_cnt), 64'd0);
    chk("post_rst_err", 64'(err_wb), 64'd0);
    idle();
    cyc();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_rd_wen = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_data   = $urandom;
      wb_addr   = 5'($urandom_range(0, 31));
      if (wb_valid && !m_busy[wb_addr] && $urandom_range(0, 15) != 0) begin
        for (int j = 0; j < 32; j++) begin
          if (m_busy[(int'(wb_addr) + j) % 32]) begin
            wb_addr = 5'((int'(wb_addr) + j) % 32);
            break;
          end
        end
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_opfetch.md
YSYX_23060208_OPFETCH -- requirements
Module: ysyx_23060208_opfetch

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 5, register-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register-data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: port clock, in, 1, sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have in_valid, in, 1, decoded instruction present.
REQ-006 SHALL have in_ready, out, 1, instruction accepted this cycle when in_valid is also high.
REQ-007 SHALL have in_rs1 and in_rs2, in, REG_WIDTH each, source register indices.
REQ-008 SHALL have in_rd, in, REG_WIDTH, destination register index.
REQ-009 SHALL have in_rd_wen, in, 1, instruction will write in_rd.
REQ-010 SHALL have raddr1 and raddr2, out, REG_WIDTH each, regfile read addresses.
REQ-011 SHALL have rdata1 and rdata2, in, DATA_WIDTH each, regfile read data, combinational in raddr.
REQ-012 SHALL have wb_valid, in, 1; wb_addr, in, REG_WIDTH; wb_data, in, DATA_WIDTH: writeback from execute.
REQ-013 SHALL have rf_wen, out, 1; rf_waddr, out, REG_WIDTH; rf_wdata, out, DATA_WIDTH: regfile write port.
REQ-014 SHALL have out_valid, out, 1, and out_ready, in, 1, issue handshake.
REQ-015 SHALL have out_src1 and out_src2, out, DATA_WIDTH each; out_rd, out, REG_WIDTH; out_rd_wen, out, 1.
REQ-016 SHALL have busy_cnt, out, REG_WIDTH+1, number of pending destinations.
REQ-017 SHALL have err_wb, out, 1, sticky flag for unexpected writeback.

Function
REQ-018 SHALL keep scoreboard busy[0..2^REG_WIDTH-1]; busy[0] SHALL always read 0.
REQ-019 SHALL drive raddr1=in_rs1 and raddr2=in_rs2 combinationally.
REQ-020 SHALL treat clr as wb_valid AND wb_addr!=0, clearing busy[wb_addr] at the clock edge.
REQ-021 SHALL flag a RAW hazard when busy[rsN] is set and not cleared by clr this cycle.
REQ-022 SHALL flag a WAW hazard when in_rd_wen is high, busy[in_rd] is set, and it is not cleared by clr this cycle.
REQ-023 SHALL assert in_ready only when out is free (out_valid==0 or out_ready==1), no hazard exists, and reset is low; in_ready SHALL NOT depend on in_valid.
REQ-024 SHALL bypass each operand: wb_data when clr and wb_addr==rsN, else 0 when rsN==0, else rdataN.
REQ-025 SHALL, on accept (in_valid and in_ready), register operands, in_rd and in_rd_wen into the out_* fields and set out_valid on the next cycle; latency is 1 cycle.
REQ-026 SHALL, on accept with in_rd_wen=1 and in_rd!=0, set busy[in_rd]; when set and clear target the same index in one cycle, set SHALL win.
REQ-027 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-028 SHALL clear out_valid after out_valid and out_ready are both high with no new accept.
REQ-029 SHALL drive rf_wen=clr, rf_waddr=wb_addr and rf_wdata=wb_data in the same cycle.
REQ-030 SHALL set err_wb when clr targets a register whose busy bit is 0; err_wb SHALL stay set until reset.
REQ-031 SHALL make busy_cnt equal the population count of busy, registered, and consistent with the scoreboard after each edge.

Reset
REQ-032 SHALL, while reset is high at an edge, clear busy, out_valid, out_* fields, busy_cnt and err_wb to 0.
REQ-033 SHALL hold in_ready and rf_wen at 0 during reset; an instruction in flight mid-operation SHALL be discarded.

Structure
REQ-034 SHALL take REG_WIDTH and DATA_WIDTH defaults from the shared ysyx_23060208 constants package, together with the x0 index constant.
REQ-035 SHALL place the scoreboard, its set/clear logic and busy_cnt in sub-module ysyx_23060208_scoreboard.

Verification
REQ-036 SHALL cover: issue rs1=1, rs2=2, rd=3, wen=1 with x1=5, x2=7 -> next cycle out_src1=5, out_src2=7, busy_cnt=1.
REQ-037 SHALL cover: x3 busy, issue rs1=3 -> in_ready=0 until wb_valid with addr 3, data 0xAB; in that cycle in_ready=1 and out_src1=0xAB one cycle later.
REQ-038 SHALL cover: out_ready=0 for 4 cycles with out_valid=1 -> out_* unchanged and in_ready=0; then out_ready=1 -> back-to-back accept.
REQ-039 SHALL cover: issue rd=0, wen=1, then read rs1=0 -> busy_cnt=0, out_src1=0, rf_wen=0.
REQ-040 SHALL cover: wb_valid with addr 9 while busy[9]=0 -> err_wb=1 and stays 1 until reset.
REQ-041 SHALL cover: reset asserted with out_valid=1 and busy_cnt=2 -> next cycle out_valid=0, busy_cnt=0, err_wb=0.
